// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment scan controller.
//   GLYPH_TAB  - 16-entry gfedcba glyph table, active-high
//   SEG_OFF    - seg_d value with every segment and the decimal point dark
//   hex2seg()  - 4-bit value to glyph; values 10..15 blank in BCD mode
//   slot_mask()- low-bit mask of the prescaler that spans one digit slot
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] GLYPH_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] val, input logic hex_en);
        logic [6:0] g;
        if (!hex_en && val > 4'd9) begin
            g = 7'h00;
        end else begin
            g = GLYPH_TAB[val];
        end
        return g;
    endfunction

    // Slot length is 2^(r+1) clocks with r = max(rate, 2), so the slot ends
    // when the low r+1 prescaler bits are all ones.
    function automatic logic [15:0] slot_mask(input logic [3:0] rate);
        logic [3:0] r;
        r = (rate < 4'd2) ? 4'd2 : rate;
        return 16'((32'd2 << r) - 32'd1);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational 4-bit to 7-segment glyph decode.
//   val_i    - digit value
//   hex_en_i - 1 = show A..F, 0 = blank values 10..15
//   seg_o    - gfedcba, active-high
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       hex_en_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(val_i, hex_en_i);

endmodule

// File: rtl/seg_scan_ctl.sv
// seg_scan_ctl: multiplexed 7-segment scan controller for N_DIG digits.
//   clk, rst     - clock, synchronous active-high reset
//   en           - display enable; low clears counters and darkens outputs
//   rate         - slot length 2^(max(rate,2)+1) clocks
//   bright       - PWM duty (bright+1)/16
//   hex_en, lzb  - glyph mode and leading-zero blanking
//   digits, dp   - packed 4-bit digit values and decimal points, digit 0 rightmost
//   seg_d        - {dp, g..a}, polarity per SEG_ACT_LOW
//   seg_com      - one-hot digit select, polarity per COM_ACT_LOW
//   frame_start  - pulse on the first output cycle of digit 0's slot
module seg_scan_ctl
    import seg_pkg::*;
#(
    parameter int N_DIG       = 8,
    parameter int BLANK_CYC   = 2,
    parameter bit COM_ACT_LOW = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         rate,
    input  logic [3:0]         bright,
    input  logic               hex_en,
    input  logic               lzb,
    input  logic [4*N_DIG-1:0] digits,
    input  logic [N_DIG-1:0]   dp,
    output logic [7:0]         seg_d,
    output logic [N_DIG-1:0]   seg_com,
    output logic               frame_start
);

    localparam int             IW       = $clog2(N_DIG);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_DIG - 1);
    localparam logic [N_DIG-1:0] COM_INV = {N_DIG{COM_ACT_LOW}};
    localparam logic [7:0]     SEG_INV  = {8{SEG_ACT_LOW}};

    // Scan state
    logic [15:0]        pcnt_q, pcnt_d;
    logic [3:0]         pwm_q, pwm_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               run_q, run_d;   // enabled on the previous clock
    logic               fs_q, fs_d;     // current cycle is the first of a frame

    // Frame shadows
    logic [4*N_DIG-1:0] sh_digits_q, sh_digits_d;
    logic [N_DIG-1:0]   sh_dp_q, sh_dp_d;
    logic               sh_lzb_q, sh_lzb_d;
    logic               sh_hex_q, sh_hex_d;

    // Output registers
    logic [7:0]         seg_d_q, seg_d_d;
    logic [N_DIG-1:0]   seg_com_q, seg_com_d;
    logic               frame_start_q, frame_start_d;

    logic [15:0]        mask;
    logic [15:0]        pcnt_low;
    logic               slot_end;
    logic               load;
    logic               blank_cur;
    logic               active;
    logic [6:0]         glyph;
    logic [N_DIG-1:0]   com_act;

    assign mask     = slot_mask(rate);
    assign pcnt_low = pcnt_q & mask;
    assign slot_end = (pcnt_low == mask);

    // Next-state logic for counters and shadows.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        pcnt_d      = pcnt_q;
        pwm_d       = pwm_q;
        idx_d       = idx_q;
        run_d       = run_q;
        fs_d        = 1'b0;
        load        = 1'b0;

        if (!en) begin
            pcnt_d = '0;
            pwm_d  = '0;
            idx_d  = '0;
            run_d  = 1'b0;
        end else if (!run_q) begin
            // First enabled clock: counters stay at zero so the next cycle is
            // cycle 0 of digit 0 with freshly loaded shadows.
            run_d = 1'b1;
            fs_d  = 1'b1;
            load  = 1'b1;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
            pwm_d  = pwm_q + 4'd1;
            if (slot_end) begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    fs_d  = 1'b1;
                    load  = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end

        sh_digits_d = load ? digits : sh_digits_q;
        sh_dp_d     = load ? dp     : sh_dp_q;
        sh_lzb_d    = load ? lzb    : sh_lzb_q;
        sh_hex_d    = load ? hex_en : sh_hex_q;
    end

    // Leading-zero blank for the current digit: walk down from the top digit
    // while digits and decimal points stay zero. Digit 0 is never visited.
    always_comb begin
        logic zero_run;
        zero_run  = sh_lzb_q;
        blank_cur = 1'b0;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            zero_run = zero_run && (sh_digits_q[4*k +: 4] == 4'd0) && !sh_dp_q[k];
            if (IW'(k) == idx_q) begin
                blank_cur = zero_run;
            end
        end
    end

    seg_decode u_decode (
        .val_i    (sh_digits_q[4*idx_q +: 4]),
        .hex_en_i (sh_hex_q),
        .seg_o    (glyph)
    );

    // Output decode from the current state; registered below.
    always_comb begin
        active = en && run_q && (pcnt_low >= 16'(BLANK_CYC)) && (pwm_q <= bright) && !blank_cur;

        com_act        = '0;
        com_act[idx_q] = 1'b1;

        seg_com_d     = (active ? com_act : '0) ^ COM_INV;
        seg_d_d       = (active ? {sh_dp_q[idx_q], glyph} : SEG_OFF) ^ SEG_INV;
        frame_start_d = fs_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before this edge.
        if (rst) begin
            pcnt_q        <= '0;
            pwm_q         <= '0;
            idx_q         <= '0;
            run_q         <= 1'b0;
            fs_q          <= 1'b0;
            // NOTE: the shadows are ordinary flops, not a RAM, and are reset
            // so the first frame after reset has defined content.
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_lzb_q      <= 1'b0;
            sh_hex_q      <= 1'b0;
            seg_d_q       <= SEG_OFF ^ SEG_INV;
            seg_com_q     <= COM_INV;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            pwm_q         <= pwm_d;
            idx_q         <= idx_d;
            run_q         <= run_d;
            fs_q          <= fs_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_lzb_q      <= sh_lzb_d;
            sh_hex_q      <= sh_hex_d;
            seg_d_q       <= seg_d_d;
            seg_com_q     <= seg_com_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_d       = seg_d_q;
    assign seg_com     = seg_com_q;
    assign frame_start = frame_start_q;

endmodule
